pmem_arbiter: RTL and testbench



---
 rtl/pmem_arbiter.sv | 103 ++++++++++
 tb/tb_pmem_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/pmem_arbiter.sv
// Shares one physical memory port between I-cache and D-cache; D wins ties, or round-robin with PMEM_ARB_RR_EN.
// Strobes assert 1 cycle after a request is seen in IDLE; requesters hold until their resp, which is combinational with pmem_resp.
module pmem_arbiter #(
  parameter int ADDR_W = 16,
  parameter int LINE_W = 128
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_pmem_read,
  input  logic [ADDR_W-1:0] i_pmem_address,
  output logic [LINE_W-1:0] i_pmem_rdata,
  output logic              i_pmem_resp,
  input  logic              d_pmem_read,
  input  logic              d_pmem_write,
  input  logic [ADDR_W-1:0] d_pmem_address,
  input  logic [LINE_W-1:0] d_pmem_wdata,
  output logic [LINE_W-1:0] d_pmem_rdata,
  output logic              d_pmem_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_address,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp
);

  typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D} state_t;
  typedef enum logic {SIDE_I, SIDE_D} side_t;

  state_t state;
  side_t  last_grant;
  logic   i_req;
  logic   d_req;
  logic   pick_d;

  assign i_req = i_pmem_read;
  assign d_req = d_pmem_read | d_pmem_write;

`ifdef PMEM_ARB_RR_EN
  // On a tie the side that did not win last time goes next
  assign pick_d = d_req && (!i_req || last_grant == SIDE_I);
`else
  // last_grant is tracked but does not steer grants: D always wins a tie
  assign pick_d = d_req || (d_req && last_grant == SIDE_I);
`endif

  assign i_pmem_rdata = pmem_rdata;
  assign d_pmem_rdata = pmem_rdata;

  // A withdrawn request never gets a resp, even if memory answers that cycle
  assign i_pmem_resp = (state == GRANT_I) && i_req && pmem_resp;
  assign d_pmem_resp = (state == GRANT_D) && d_req && pmem_resp;

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      last_grant   <= SIDE_D;
      pmem_read    <= 1'b0;
      pmem_write   <= 1'b0;
      pmem_address <= '0;
      pmem_wdata   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_d) begin
            state        <= GRANT_D;
            last_grant   <= SIDE_D;
            pmem_address <= d_pmem_address;
            pmem_wdata   <= d_pmem_wdata;
            pmem_write   <= d_pmem_write;
            pmem_read    <= !d_pmem_write;
          end else if (i_req) begin
            state        <= GRANT_I;
            last_grant   <= SIDE_I;
            pmem_address <= i_pmem_address;
            pmem_write   <= 1'b0;
            pmem_read    <= 1'b1;
          end
        end
        GRANT_I: begin
          if (!i_req || pmem_resp) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        GRANT_D: begin
          if (!d_req || pmem_resp) begin
            state      <= IDLE;
            pmem_read  <= 1'b0;
            pmem_write <= 1'b0;
          end
        end
        default: begin
          state      <= IDLE;
          pmem_read  <= 1'b0;
          pmem_write <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pmem_arbiter.sv
// Bench for pmem_arbiter: table of request patterns plus hand sequences, grant order checked against a scoreboard queue.
module tb_pmem_arbiter;
  localparam int ADDR_W = 16;
  localparam int LINE_W = 128;

  logic              clk = 1'b0;
  logic              rst;
  logic              i_pmem_read;
  logic [ADDR_W-1:0] i_pmem_address;
  logic [LINE_W-1:0] i_pmem_rdata;
  logic              i_pmem_resp;
  logic              d_pmem_read;
  logic              d_pmem_write;
  logic [ADDR_W-1:0] d_pmem_address;
  logic [LINE_W-1:0] d_pmem_wdata;
  logic [LINE_W-1:0] d_pmem_rdata;
  logic              d_pmem_resp;
  logic              pmem_read;
  logic              pmem_write;
  logic [ADDR_W-1:0] pmem_address;
  logic [LINE_W-1:0] pmem_wdata;
  logic [LINE_W-1:0] pmem_rdata;
  logic              pmem_resp;

  pmem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W)) dut (
    .clk(clk), .rst(rst),
    .i_pmem_read(i_pmem_read), .i_pmem_address(i_pmem_address),
    .i_pmem_rdata(i_pmem_rdata), .i_pmem_resp(i_pmem_resp),
    .d_pmem_read(d_pmem_read), .d_pmem_write(d_pmem_write),
    .d_pmem_address(d_pmem_address), .d_pmem_wdata(d_pmem_wdata),
    .d_pmem_rdata(d_pmem_rdata), .d_pmem_resp(d_pmem_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata),
    .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic              i_rd;
    logic              d_rd;
    logic              d_wr;
    logic [ADDR_W-1:0] i_addr;
    logic [ADDR_W-1:0] d_addr;
    logic [LINE_W-1:0] wdata;
    logic [LINE_W-1:0] rdata;
    int                lat;
  } vec_t;

  typedef struct {
    logic              is_d;
    logic              wr;
    logic [ADDR_W-1:0] addr;
    logic [LINE_W-1:0] wdata;
  } exp_t;

  vec_t vecs[6];
  exp_t sbq[$];
  int   checks = 0;
  int   passes = 0;
  logic mdl_last_d = 1'b1;

  task automatic chk(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] req);
    checks++;
    if (act === req) passes++;
    else $display("FAIL %s: got %h want %h", name, act, req);
  endtask

  function automatic logic tie_d();
`ifdef PMEM_ARB_RR_EN
    return !mdl_last_d;
`else
    return 1'b1;
`endif
  endfunction

  // Expected grants are pushed in the order the arbiter should issue them
  task automatic push_exp(input logic is_d);
    exp_t e;
    e.is_d  = is_d;
    e.wr    = is_d && d_pmem_write;
    e.addr  = is_d ? d_pmem_address : i_pmem_address;
    e.wdata = d_pmem_wdata;
    sbq.push_back(e);
    mdl_last_d = is_d;
  endtask

  // Memory model: checks the next grant, answers after lat cycles, checks the resp routing
  task automatic serve(input int lat, input logic [LINE_W-1:0] rd, input bit keep);
    exp_t e;
    @(negedge clk);
    if (sbq.size() == 0) begin
      checks++;
      $display("FAIL sb_underflow: strobes %b%b with no expected grant", pmem_read, pmem_write);
      return;
    end
    e = sbq.pop_front();
    chk("grant_read", LINE_W'(pmem_read), LINE_W'(!e.wr));
    chk("grant_write", LINE_W'(pmem_write), LINE_W'(e.wr));
    chk("grant_addr", LINE_W'(pmem_address), LINE_W'(e.addr));
    if (e.wr) chk("grant_wdata", pmem_wdata, e.wdata);
    for (int k = 1; k < lat; k++) begin
      @(negedge clk);
      chk("hold_strobe", LINE_W'({pmem_read, pmem_write}), LINE_W'({!e.wr, e.wr}));
      chk("early_resp", LINE_W'({i_pmem_resp, d_pmem_resp}), '0);
    end
    @(negedge clk);
    pmem_rdata = rd;
    pmem_resp  = 1'b1;
    #1;
    chk("i_resp", LINE_W'(i_pmem_resp), LINE_W'(!e.is_d));
    chk("d_resp", LINE_W'(d_pmem_resp), LINE_W'(e.is_d));
    chk("rdata", e.is_d ? d_pmem_rdata : i_pmem_rdata, rd);
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("strobe_drop", LINE_W'({pmem_read, pmem_write}), '0);
    chk("resp_pulse", LINE_W'({i_pmem_resp, d_pmem_resp}), '0);
    if (!keep) begin
      if (e.is_d) begin
        d_pmem_read  = 1'b0;
        d_pmem_write = 1'b0;
      end else begin
        i_pmem_read = 1'b0;
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic w;
    logic both;
    vec_t v;

    vecs[0] = '{1'b1, 1'b0, 1'b0, 16'h1230, 16'h0000, '0, {8{16'hAAAA}}, 3};
    vecs[1] = '{1'b0, 1'b0, 1'b1, 16'h0000, 16'h4560,
                128'h0123_4567_89AB_CDEF_0123_4567_89AB_CDEF, '0, 2};
    vecs[2] = '{1'b1, 1'b1, 1'b0, 16'h0010, 16'h0020, '0, {4{32'hDEAD_BEEF}}, 1};
    vecs[3] = '{1'b0, 1'b1, 1'b1, 16'h0000, 16'h0770, {8{16'h5555}}, '0, 2};
    vecs[4] = '{1'b1, 1'b0, 1'b1, 16'h2220, 16'h3330, {4{32'hCAFE_F00D}}, {4{32'h1357_9BDF}}, 4};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h8880, '0, {2{64'h0F0F_F0F0_1234_5678}}, 1};

    rst = 1'b1;
    i_pmem_read = 1'b0; i_pmem_address = '0;
    d_pmem_read = 1'b0; d_pmem_write = 1'b0; d_pmem_address = '0; d_pmem_wdata = '0;
    pmem_rdata = '0; pmem_resp = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_strobes", LINE_W'({pmem_read, pmem_write}), '0);
    chk("rst_addr", LINE_W'(pmem_address), '0);
    chk("rst_wdata", pmem_wdata, '0);
    chk("rst_resp", LINE_W'({i_pmem_resp, d_pmem_resp}), '0);
    rst = 1'b0;

    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    chk("idle_resp_ignored", LINE_W'({i_pmem_resp, d_pmem_resp}), '0);
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("idle_no_strobe", LINE_W'({pmem_read, pmem_write}), '0);

    foreach (vecs[n]) begin
      v = vecs[n];
      i_pmem_read = v.i_rd; i_pmem_address = v.i_addr;
      d_pmem_read = v.d_rd; d_pmem_write = v.d_wr;
      d_pmem_address = v.d_addr; d_pmem_wdata = v.wdata;
      both = v.i_rd && (v.d_rd || v.d_wr);
      if (both) begin
        w = tie_d();
        push_exp(w);
        push_exp(!w);
      end else begin
        push_exp(v.d_rd || v.d_wr);
      end
      serve(v.lat, v.rdata, 1'b0);
      if (both) serve(v.lat, ~v.rdata, 1'b0);
      @(negedge clk);
      chk("idle_after_vec", LINE_W'({pmem_read, pmem_write}), '0);
    end

    // Requester withdraws while granted: strobe drops, late resp goes nowhere
    i_pmem_read = 1'b1; i_pmem_address = 16'h0400;
    mdl_last_d = 1'b0;
    @(negedge clk);
    chk("wd_grant", LINE_W'({pmem_read, pmem_address}), LINE_W'({1'b1, 16'h0400}));
    i_pmem_read = 1'b0;
    @(negedge clk);
    chk("wd_drop", LINE_W'({pmem_read, pmem_write}), '0);
    pmem_resp = 1'b1;
    #1;
    chk("wd_no_resp", LINE_W'({i_pmem_resp, d_pmem_resp}), '0);
    @(negedge clk);
    pmem_resp = 1'b0;

    // D re-requests straight after its resp while I has been waiting
    d_pmem_read = 1'b1; d_pmem_write = 1'b0; d_pmem_address = 16'h0100;
    i_pmem_address = 16'h0200;
    push_exp(1'b1);
    @(posedge clk);
    #1 i_pmem_read = 1'b1;
    serve(2, {8{16'h1111}}, 1'b1);
    w = tie_d();
    push_exp(w);
    push_exp(!w);
    serve(1, {8{16'h2222}}, 1'b0);
    serve(2, {8{16'h3333}}, 1'b0);
    @(negedge clk);
    chk("b2b_idle", LINE_W'({pmem_read, pmem_write}), '0);

    // Reset two cycles into an I read
    i_pmem_read = 1'b1; i_pmem_address = 16'h0300;
    @(negedge clk);
    chk("rst_mid_grant", LINE_W'({pmem_read, pmem_address}), LINE_W'({1'b1, 16'h0300}));
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_drop", LINE_W'({pmem_read, pmem_write}), '0);
    rst = 1'b0; i_pmem_read = 1'b0;
    mdl_last_d = 1'b1;
    @(negedge clk);
    pmem_resp = 1'b1;
    #1;
    chk("rst_mid_no_resp", LINE_W'({i_pmem_resp, d_pmem_resp}), '0);
    @(negedge clk);
    pmem_resp = 1'b0;
    chk("rst_mid_idle", LINE_W'({pmem_read, pmem_write}), '0);
    if (sbq.size() != 0) begin
      checks++;
      $display("FAIL sb_leftover: %0d expected grants never seen", sbq.size());
    end

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
